// File: rtl/regfile_fwd_sb.sv
// Register file with registered read ports, EX/MEM forwarding and a
// per-register pending-write scoreboard that drives operand ready flags.
module regfile_fwd_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_imm,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_rdy,
    output logic                     rd_valid,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     fex_en,
    input  logic [ADDR_W-1:0]        fex_addr,
    input  logic [DATA_W-1:0]        fex_data,
    input  logic                     fmem_en,
    input  logic [ADDR_W-1:0]        fmem_addr,
    input  logic [DATA_W-1:0]        fmem_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [2**ADDR_W-1:0]     busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0]        regs [DEPTH];
    logic [ADDR_W-1:0]        addr [NUM_RD];
    logic [DEPTH-1:0]         busy_d;
    logic [NUM_RD*DATA_W-1:0] data_d;
    logic [NUM_RD-1:0]        rdy_d;
    logic                     wr_ok;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_addr
        assign addr[g] = rd_addr[g*ADDR_W +: ADDR_W];
    end

    assign wr_ok = wb_en && !(ZR && (wb_addr == '0));

    // Operand select: first matching source wins, array read is last resort.
    always_comb begin
        data_d = '0;
        rdy_d  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_imm[i]) begin
                data_d[i*DATA_W +: DATA_W] = DATA_W'(addr[i]);
                rdy_d[i] = 1'b1;
            end else if (ZR && (addr[i] == '0)) begin
                data_d[i*DATA_W +: DATA_W] = '0;
                rdy_d[i] = 1'b1;
            end else if (fex_en && (fex_addr == addr[i])) begin
                data_d[i*DATA_W +: DATA_W] = fex_data;
                rdy_d[i] = 1'b1;
            end else if (fmem_en && (fmem_addr == addr[i])) begin
                data_d[i*DATA_W +: DATA_W] = fmem_data;
                rdy_d[i] = 1'b1;
            end else if (wb_en && (wb_addr == addr[i])) begin
                data_d[i*DATA_W +: DATA_W] = wb_data;
                rdy_d[i] = 1'b1;
            end else begin
                data_d[i*DATA_W +: DATA_W] = regs[addr[i]];
                rdy_d[i] = ~busy[addr[i]];
            end
        end
    end

    // A new producer supersedes a retiring one to the same register.
    always_comb begin
        busy_d = busy;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
        if (ZR) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else if (wr_ok) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= '0;
            rd_data  <= '0;
            rd_rdy   <= '0;
            rd_valid <= 1'b0;
        end else begin
            busy     <= busy_d;
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= data_d;
                rd_rdy  <= rdy_d;
            end
        end
    end

endmodule
